exit_gate_controller: RTL
=========================

// Module: exit_gate_controller
// PURPOSE
//  Exit-side counterpart of the parking entry logic. Sequences the exit barrier
//  (car detected -> ticket check -> gate open -> car passed -> close).
//  Sole owner of the free-space counter parking_capacity that the entry side reads.
//  Entry side reports each admitted car with a one-cycle entry_taken pulse.
// PARAMETERS
//  CAP_W         8    width of parking_capacity
//  MAX_CAPACITY  200  free spaces after reset; upper bound of counter (<= 2**CAP_W-1)
//  PAY_TIMEOUT   64   cycles allowed in VERIFY for a ticket result
//  GATE_TIMEOUT  32   cycles gate stays open waiting for car_passed
// PORTS
//  clk               in   1      system clock, rising edge
//  rst               in   1      async active-high reset
//  exit              in   1      level: car present at exit sensor
//  ticket_valid      in   1      1-cycle pulse: ticket/payment accepted
//  ticket_invalid    in   1      1-cycle pulse: ticket rejected
//  car_passed        in   1      1-cycle pulse: car cleared barrier
//  entry_taken       in   1      1-cycle pulse from entry side: one space consumed
//  gate_open         out  1      barrier open command (registered)
//  parking_capacity  out  CAP_W  current free spaces (registered)
//  full              out  1      parking_capacity == 0 (combinational from register)
//  exit_error        out  1      1-cycle pulse: invalid ticket or either timeout
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, armed=1, timer=0, gate_open=0,
//   exit_error=0, parking_capacity=MAX_CAPACITY.
//  FSM, one transition per clk:
//   IDLE:    gate closed. exit=1 && armed -> VERIFY, timer cleared. exit=0 -> armed=1.
//   VERIFY:  ticket_valid -> OPEN (gate_open=1 next cycle, timer cleared).
//            ticket_invalid -> IDLE, exit_error pulse, armed=0.
//            timer==PAY_TIMEOUT-1 -> IDLE, exit_error pulse, armed=0.
//            exit=0 -> IDLE, no error. Priority: valid > invalid > timeout > exit drop.
//   OPEN:    gate_open=1. car_passed -> RELEASE. timer==GATE_TIMEOUT-1 without
//            car_passed -> IDLE, gate closes, exit_error pulse, no count change (car reversed).
//            exit level ignored in OPEN.
//   RELEASE: single cycle, gate_open=0, counter increment issued, armed=0 -> IDLE.
//  armed=0 blocks re-entry to VERIFY until exit seen low >=1 cycle (one car per pass).
//  Counter update each cycle, inc = (state==RELEASE), dec = entry_taken:
//   inc&dec -> unchanged; inc only -> +1, saturate at MAX_CAPACITY;
//   dec only -> -1, saturate at 0 (entry side must not admit when full).
//   Saturated events are dropped silently. Result visible cycle after event.
//  Latency: ticket_valid -> gate_open=1 one cycle; car_passed -> capacity+1 two cycles.
//  Timer: $clog2(max(PAY_TIMEOUT,GATE_TIMEOUT)) bits, counts only in VERIFY/OPEN,
//   cleared on every state change; never wraps.
//  Pulses arriving in states that do not consume them are ignored (entry_taken always honoured).
// STRUCTURE
//  parking_defs.vh (shared, `include): CAP_W, MAX_CAPACITY default, 2-bit state
//   encodings ST_IDLE=0, ST_VERIFY=1, ST_OPEN=2, ST_RELEASE=3; reused by entry-side blocks.
//  Sub-module capacity_counter: up/down saturating counter (inc, dec, count, full);
//   FSM, timer and armed flag stay in the top module.
// TESTING
//  Reset mid-OPEN -> gate_open=0 and parking_capacity=200 same cycle, state IDLE.
//  exit=1, ticket_valid @t, car_passed @t+5 -> gate_open 1 from t+1 to t+6, capacity 199->200? no:
//   start 150 -> 151 two cycles after car_passed; exit held high: no second VERIFY until exit=0.
//  exit=1, no ticket result for 64 cycles -> exit_error single pulse, return IDLE, gate never opens.
//  ticket_valid then no car_passed for 32 cycles -> gate closes, exit_error pulse, capacity unchanged.
//  capacity=200, RELEASE -> stays 200; capacity=0, entry_taken -> stays 0, full=1.
//  RELEASE and entry_taken same cycle at capacity=10 -> remains 10; ticket_valid+ticket_invalid
//   same cycle -> OPEN.

Source files
------------

// File: rtl/exit_gate_controller_pkg.sv
// Shared definitions for the parking gate blocks: counter sizing defaults,
// barrier state encodings and the timer width helper.
package exit_gate_controller_pkg;

    localparam int CAP_W_DEF        = 8;
    localparam int MAX_CAPACITY_DEF = 200;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VERIFY  = 2'd1,
        ST_OPEN    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Width able to hold the largest timeout minus one; at least one bit.
    function automatic int timer_width(input int pay_timeout, input int gate_timeout);
        int longest;
        longest = (pay_timeout > gate_timeout) ? pay_timeout : gate_timeout;
        if (longest < 2) begin
            return 1;
        end
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/exit_gate_controller_capacity_counter.sv
// Up/down saturating free-space counter. Simultaneous inc and dec cancel;
// steps that would pass either bound are dropped.
module exit_gate_controller_capacity_counter
    import exit_gate_controller_pkg::*;
#(
    parameter int CAP_W        = CAP_W_DEF,
    parameter int MAX_CAPACITY = MAX_CAPACITY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CAP_W-1:0] count,
    output logic             full
);

    localparam logic [CAP_W-1:0] MAX_VAL = CAP_W'(MAX_CAPACITY);
    localparam logic [CAP_W-1:0] ONE     = CAP_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= MAX_VAL;
        end else if (inc && !dec) begin
            if (count != MAX_VAL) begin
                count <= count + ONE;
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - ONE;
            end
        end
    end

    assign full = (count == '0);

endmodule

// File: rtl/exit_gate_controller.sv
// Exit barrier sequencer (detect -> verify ticket -> open -> release) and the
// owner of the free-space counter that the entry side reads.
module exit_gate_controller
    import exit_gate_controller_pkg::*;
#(
    parameter int CAP_W        = CAP_W_DEF,
    parameter int MAX_CAPACITY = MAX_CAPACITY_DEF,
    parameter int PAY_TIMEOUT  = 64,
    parameter int GATE_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exit,
    input  logic             ticket_valid,
    input  logic             ticket_invalid,
    input  logic             car_passed,
    input  logic             entry_taken,
    output logic             gate_open,
    output logic [CAP_W-1:0] parking_capacity,
    output logic             full,
    output logic             exit_error,
    output state_t           fsm_state
);

    localparam int TW = timer_width(PAY_TIMEOUT, GATE_TIMEOUT);
    localparam logic [TW-1:0] PAY_LAST  = TW'(PAY_TIMEOUT - 1);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_TIMEOUT - 1);
    localparam logic [TW-1:0] TICK      = TW'(1);

    state_t        state;
    logic          armed;
    logic [TW-1:0] timer;

    // armed drops after each completed or failed pass so a car still sitting
    // on the sensor cannot trigger a second verification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            armed      <= 1'b1;
            timer      <= '0;
            gate_open  <= 1'b0;
            exit_error <= 1'b0;
        end else begin
            exit_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gate_open <= 1'b0;
                    timer     <= '0;
                    if (exit && armed) begin
                        state <= ST_VERIFY;
                    end else if (!exit) begin
                        armed <= 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (ticket_valid) begin
                        state     <= ST_OPEN;
                        gate_open <= 1'b1;
                        timer     <= '0;
                    end else if (ticket_invalid || timer == PAY_LAST) begin
                        state      <= ST_IDLE;
                        exit_error <= 1'b1;
                        armed      <= 1'b0;
                        timer      <= '0;
                    end else if (!exit) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + TICK;
                    end
                end
                ST_OPEN: begin
                    if (car_passed) begin
                        state     <= ST_RELEASE;
                        gate_open <= 1'b0;
                        timer     <= '0;
                    end else if (timer == GATE_LAST) begin
                        // Car backed away: close without touching the count.
                        state      <= ST_IDLE;
                        gate_open  <= 1'b0;
                        exit_error <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TICK;
                    end
                end
                ST_RELEASE: begin
                    state     <= ST_IDLE;
                    gate_open <= 1'b0;
                    armed     <= 1'b0;
                    timer     <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    gate_open <= 1'b0;
                    timer     <= '0;
                end
            endcase
        end
    end

    assign fsm_state = state;

    exit_gate_controller_capacity_counter #(
        .CAP_W        (CAP_W),
        .MAX_CAPACITY (MAX_CAPACITY)
    ) u_capacity (
        .clk   (clk),
        .rst   (rst),
        .inc   (state == ST_RELEASE),
        .dec   (entry_taken),
        .count (parking_capacity),
        .full  (full)
    );

endmodule
